// File: rtl/ipsxe_floating_point_fl2fl_stream_v1_0.sv
`default_nettype none
// ============================================================================
// Module  : ipsxe_floating_point_fl2fl_stream_v1_0
// Brief   : Floating-point precision converter with an AXI4-Stream handshake,
//           runtime rounding mode, TUSER pass-through and IEEE status flags.
//           Three-stage bubble-collapsing pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module ipsxe_floating_point_fl2fl_stream_v1_0 #(
    parameter int FLOAT_IN_EXP   = 8,
    parameter int FLOAT_IN_FRAC  = 24,
    parameter int FLOAT_OUT_EXP  = 11,
    parameter int FLOAT_OUT_FRAC = 53,
    parameter int TUSER_WIDTH    = 1
) (
    input  logic                                    i_aclk,
    input  logic                                    i_areset,
    input  logic                                    i_aclken,
    input  logic [FLOAT_IN_EXP+FLOAT_IN_FRAC-1:0]   i_axi4s_a_tdata,
    input  logic [TUSER_WIDTH-1:0]                  i_axi4s_a_tuser,
    input  logic [1:0]                              i_round_mode,
    input  logic                                    i_axi4s_a_tvalid,
    output logic                                    o_axi4s_a_tready,
    output logic [FLOAT_OUT_EXP+FLOAT_OUT_FRAC-1:0] o_axi4s_result_tdata,
    output logic [TUSER_WIDTH-1:0]                  o_axi4s_result_tuser,
    output logic                                    o_axi4s_result_tvalid,
    input  logic                                    i_axi4s_result_tready,
    output logic                                    o_overflow,
    output logic                                    o_underflow,
    output logic                                    o_invalid,
    output logic                                    o_inexact
);

    localparam int c_OW  = FLOAT_OUT_EXP + FLOAT_OUT_FRAC;
    localparam int c_FIN = FLOAT_IN_FRAC - 1;
    localparam int c_FON = FLOAT_OUT_FRAC - 1;
    localparam int c_EW  = FLOAT_IN_EXP + FLOAT_OUT_EXP + 2;

    // Output bias minus input bias, folded into one signed constant
    localparam logic signed [c_EW-1:0] c_REBIAS =
        c_EW'((1 << (FLOAT_OUT_EXP-1)) - (1 << (FLOAT_IN_EXP-1)));
    localparam logic signed [c_EW-1:0] c_EXP_MAX = c_EW'((1 << FLOAT_OUT_EXP) - 1);

    localparam logic [1:0] c_RNE = 2'd0;
    localparam logic [1:0] c_RTZ = 2'd1;
    localparam logic [1:0] c_RUP = 2'd2;
    localparam logic [1:0] c_RDN = 2'd3;

    localparam logic [c_OW-1:0] c_QNAN =
        {1'b0, {FLOAT_OUT_EXP{1'b1}}, 1'b1, {(c_FON-1){1'b0}}};
    localparam logic [c_OW-2:0] c_INF_MAG = {{FLOAT_OUT_EXP{1'b1}}, {c_FON{1'b0}}};
    localparam logic [c_OW-2:0] c_MAX_MAG = {{(FLOAT_OUT_EXP-1){1'b1}}, 1'b0, {c_FON{1'b1}}};

    // ---------------------------------------------------------------- handshake
    logic s1_v_q, s2_v_q, s3_v_q;
    logic ld1, ld2, ld3, acc_in;

    assign ld3              = i_aclken & (~s3_v_q | i_axi4s_result_tready);
    assign ld2              = i_aclken & (~s2_v_q | ld3);
    assign ld1              = i_aclken & (~s1_v_q | ld2);
    assign o_axi4s_a_tready = ld1 & ~i_areset;
    assign acc_in           = i_axi4s_a_tvalid & o_axi4s_a_tready;

    // ---------------------------------------------------------------- stage 1
    logic                     in_sign;
    logic [FLOAT_IN_EXP-1:0]  in_exp;
    logic [c_FIN-1:0]         in_frac;
    logic                     exp_ones, exp_zero, frac_zero;

    assign {in_sign, in_exp, in_frac} = i_axi4s_a_tdata;
    assign exp_ones  = &in_exp;
    assign exp_zero  = ~|in_exp;
    assign frac_zero = ~|in_frac;

    logic                    s1_sign_q, s1_nan_q, s1_snan_q, s1_inf_q, s1_zero_q, s1_sub_q;
    logic signed [c_EW-1:0]  s1_e_q;
    logic [c_FIN-1:0]        s1_frac_q;
    logic [1:0]              s1_mode_q;
    logic [TUSER_WIDTH-1:0]  s1_user_q;

    // S1: capture the operand, classify it and rebias the exponent
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_snan_q <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_sub_q  <= 1'b0;
            s1_e_q    <= '0;
            s1_frac_q <= '0;
            s1_mode_q <= 2'd0;
            s1_user_q <= '0;
        end else if (ld1) begin
            s1_v_q <= acc_in;
            if (acc_in) begin
                s1_sign_q <= in_sign;
                s1_nan_q  <= exp_ones & ~frac_zero;
                s1_snan_q <= exp_ones & ~frac_zero & ~in_frac[c_FIN-1];
                s1_inf_q  <= exp_ones & frac_zero;
                s1_zero_q <= exp_zero & frac_zero;
                s1_sub_q  <= exp_zero & ~frac_zero;
                s1_e_q    <= $signed({{(c_EW-FLOAT_IN_EXP){1'b0}}, in_exp}) + c_REBIAS;
                s1_frac_q <= in_frac;
                s1_mode_q <= i_round_mode;
                s1_user_q <= i_axi4s_a_tuser;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    // Sum carries one extra MSB so a rounding carry-out is visible to S3
    logic [c_FON:0] s2_sum_d;
    logic           s2_inexact_d;

    generate
        if (FLOAT_OUT_FRAC > FLOAT_IN_FRAC) begin : g_widen
            assign s2_sum_d     = {1'b0, s1_frac_q, {(FLOAT_OUT_FRAC-FLOAT_IN_FRAC){1'b0}}};
            assign s2_inexact_d = 1'b0;
        end else if (FLOAT_OUT_FRAC == FLOAT_IN_FRAC) begin : g_same
            assign s2_sum_d     = {1'b0, s1_frac_q};
            assign s2_inexact_d = 1'b0;
        end else begin : g_narrow
            localparam int c_D = FLOAT_IN_FRAC - FLOAT_OUT_FRAC;
            // Two zero pad bits keep guard/round/sticky indexing legal for any drop count
            logic [c_FIN+1:0] frac_ext;
            logic             guard, rnd, stk, lsb, inc;

            assign frac_ext     = {s1_frac_q, 2'b00};
            assign guard        = frac_ext[c_D+1];
            assign rnd          = frac_ext[c_D];
            assign stk          = |frac_ext[c_D-1:0];
            assign lsb          = frac_ext[c_D+2];
            assign s2_inexact_d = guard | rnd | stk;

            // Round-increment decision for the selected mode
            always_comb begin
                inc = 1'b0;
                case (s1_mode_q)
                    c_RNE:   inc = guard & (rnd | stk | lsb);
                    c_RTZ:   inc = 1'b0;
                    c_RUP:   inc = ~s1_sign_q & (guard | rnd | stk);
                    default: inc = s1_sign_q & (guard | rnd | stk);
                endcase
            end

            assign s2_sum_d = {1'b0, frac_ext[c_FIN+1:c_D+2]} + (c_FON+1)'(inc);
        end
    endgenerate

    logic                    s2_sign_q, s2_nan_q, s2_snan_q, s2_inf_q, s2_zero_q, s2_sub_q;
    logic signed [c_EW-1:0]  s2_e_q;
    logic [c_FON:0]          s2_sum_q;
    logic                    s2_inexact_q;
    logic [1:0]              s2_mode_q;
    logic [TUSER_WIDTH-1:0]  s2_user_q;

    // S2: register the aligned and rounded significand
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            s2_v_q       <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_nan_q     <= 1'b0;
            s2_snan_q    <= 1'b0;
            s2_inf_q     <= 1'b0;
            s2_zero_q    <= 1'b0;
            s2_sub_q     <= 1'b0;
            s2_e_q       <= '0;
            s2_sum_q     <= '0;
            s2_inexact_q <= 1'b0;
            s2_mode_q    <= 2'd0;
            s2_user_q    <= '0;
        end else if (ld2) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_sign_q    <= s1_sign_q;
                s2_nan_q     <= s1_nan_q;
                s2_snan_q    <= s1_snan_q;
                s2_inf_q     <= s1_inf_q;
                s2_zero_q    <= s1_zero_q;
                s2_sub_q     <= s1_sub_q;
                s2_e_q       <= s1_e_q;
                s2_sum_q     <= s2_sum_d;
                s2_inexact_q <= s2_inexact_d;
                s2_mode_q    <= s1_mode_q;
                s2_user_q    <= s1_user_q;
            end
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic                   carry, to_inf;
    logic signed [c_EW-1:0] e_fin;
    logic [c_FON-1:0]       frac_fin;
    logic [c_OW-1:0]        res_d;
    logic                   ovf_d, unf_d, inv_d, inx_d;

    // Renormalise after rounding, resolve specials and range, and pack
    always_comb begin
        carry    = s2_sum_q[c_FON];
        e_fin    = s2_e_q + c_EW'(carry);
        frac_fin = carry ? '0 : s2_sum_q[c_FON-1:0];
        to_inf   = (s2_mode_q == c_RNE) | ((s2_mode_q == c_RUP) & ~s2_sign_q)
                 | ((s2_mode_q == c_RDN) & s2_sign_q);
        res_d    = '0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inv_d    = 1'b0;
        inx_d    = 1'b0;
        if (s2_nan_q) begin
            res_d = c_QNAN;
            inv_d = s2_snan_q;
        end else if (s2_inf_q) begin
            res_d = {s2_sign_q, c_INF_MAG};
        end else if (s2_zero_q) begin
            res_d = {s2_sign_q, {(c_OW-1){1'b0}}};
        end else if (s2_sub_q) begin
            res_d = {s2_sign_q, {(c_OW-1){1'b0}}};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end else if (e_fin >= c_EXP_MAX) begin
            res_d = {s2_sign_q, to_inf ? c_INF_MAG : c_MAX_MAG};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (e_fin[c_EW-1] || (e_fin == '0)) begin
            res_d = {s2_sign_q, {(c_OW-1){1'b0}}};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end else begin
            res_d = {s2_sign_q, e_fin[FLOAT_OUT_EXP-1:0], frac_fin};
            inx_d = s2_inexact_q;
        end
    end

    logic [c_OW-1:0]        s3_data_q;
    logic [TUSER_WIDTH-1:0] s3_user_q;
    logic                   s3_ovf_q, s3_unf_q, s3_inv_q, s3_inx_q;

    // S3: output register; holds while the consumer stalls
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            s3_v_q    <= 1'b0;
            s3_data_q <= '0;
            s3_user_q <= '0;
            s3_ovf_q  <= 1'b0;
            s3_unf_q  <= 1'b0;
            s3_inv_q  <= 1'b0;
            s3_inx_q  <= 1'b0;
        end else if (ld3) begin
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_data_q <= res_d;
                s3_user_q <= s2_user_q;
                s3_ovf_q  <= ovf_d;
                s3_unf_q  <= unf_d;
                s3_inv_q  <= inv_d;
                s3_inx_q  <= inx_d;
            end
        end
    end

    assign o_axi4s_result_tvalid = s3_v_q;
    assign o_axi4s_result_tdata  = s3_data_q;
    assign o_axi4s_result_tuser  = s3_user_q;
    assign o_overflow            = s3_ovf_q;
    assign o_underflow           = s3_unf_q;
    assign o_invalid             = s3_inv_q;
    assign o_inexact             = s3_inx_q;

endmodule
`default_nettype wire

// File: tb/tb_ipsxe_floating_point_fl2fl_stream_v1_0.sv
`default_nettype none
// ============================================================================
// Module  : tb_ipsxe_floating_point_fl2fl_stream_v1_0
// Brief   : Directed self-checking bench: one widening instance (8/24->11/53)
//           and one narrowing instance (11/53->8/24) on a shared clock.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ipsxe_floating_point_fl2fl_stream_v1_0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, aclken;
    int   errors = 0;
    int   checks = 0;

    // widening instance
    logic [31:0] w_a_tdata;
    logic        w_a_tuser;
    logic [1:0]  w_mode;
    logic        w_a_tvalid, w_a_tready;
    logic [63:0] w_res_tdata;
    logic        w_res_tuser, w_res_tvalid, w_res_tready;
    logic        w_ovf, w_unf, w_inv, w_inx;

    // narrowing instance
    logic [63:0] n_a_tdata;
    logic [7:0]  n_a_tuser;
    logic [1:0]  n_mode;
    logic        n_a_tvalid, n_a_tready;
    logic [31:0] n_res_tdata;
    logic [7:0]  n_res_tuser;
    logic        n_res_tvalid, n_res_tready;
    logic        n_ovf, n_unf, n_inv, n_inx;

    ipsxe_floating_point_fl2fl_stream_v1_0 #(
        .FLOAT_IN_EXP(8), .FLOAT_IN_FRAC(24), .FLOAT_OUT_EXP(11), .FLOAT_OUT_FRAC(53),
        .TUSER_WIDTH(1)
    ) u_widen (
        .i_aclk(clk), .i_areset(rst), .i_aclken(aclken),
        .i_axi4s_a_tdata(w_a_tdata), .i_axi4s_a_tuser(w_a_tuser), .i_round_mode(w_mode),
        .i_axi4s_a_tvalid(w_a_tvalid), .o_axi4s_a_tready(w_a_tready),
        .o_axi4s_result_tdata(w_res_tdata), .o_axi4s_result_tuser(w_res_tuser),
        .o_axi4s_result_tvalid(w_res_tvalid), .i_axi4s_result_tready(w_res_tready),
        .o_overflow(w_ovf), .o_underflow(w_unf), .o_invalid(w_inv), .o_inexact(w_inx)
    );

    ipsxe_floating_point_fl2fl_stream_v1_0 #(
        .FLOAT_IN_EXP(11), .FLOAT_IN_FRAC(53), .FLOAT_OUT_EXP(8), .FLOAT_OUT_FRAC(24),
        .TUSER_WIDTH(8)
    ) u_narrow (
        .i_aclk(clk), .i_areset(rst), .i_aclken(aclken),
        .i_axi4s_a_tdata(n_a_tdata), .i_axi4s_a_tuser(n_a_tuser), .i_round_mode(n_mode),
        .i_axi4s_a_tvalid(n_a_tvalid), .o_axi4s_a_tready(n_a_tready),
        .o_axi4s_result_tdata(n_res_tdata), .o_axi4s_result_tuser(n_res_tuser),
        .o_axi4s_result_tvalid(n_res_tvalid), .i_axi4s_result_tready(n_res_tready),
        .o_overflow(n_ovf), .o_underflow(n_unf), .o_invalid(n_inv), .o_inexact(n_inx)
    );

    // Send one operand to the narrowing instance and wait for its result.
    // On timeout the outputs are X so any following comparison fails.
    task automatic run_n(input logic [63:0] a, input logic [1:0] mode, input logic [7:0] user,
                         output logic [31:0] res, output logic [3:0] flg,
                         output logic [7:0] usr, output int lat);
        @(negedge clk);
        n_a_tdata = a; n_mode = mode; n_a_tuser = user; n_a_tvalid = 1'b1; n_res_tready = 1'b1;
        #1;
        for (int k = 0; k < 20 && !n_a_tready; k++) begin @(negedge clk); #1; end
        @(posedge clk);
        @(negedge clk);
        n_a_tvalid = 1'b0;
        lat = 1;
        #1;
        while (!n_res_tvalid && lat < 20) begin @(negedge clk); #1; lat++; end
        if (n_res_tvalid) begin
            res = n_res_tdata; flg = {n_ovf, n_unf, n_inv, n_inx}; usr = n_res_tuser;
        end else begin
            res = 'x; flg = 'x; usr = 'x;
        end
    endtask

    task automatic run_w(input logic [31:0] a, output logic [63:0] res, output logic [3:0] flg);
        int lat;
        @(negedge clk);
        w_a_tdata = a; w_mode = 2'd0; w_a_tuser = 1'b1; w_a_tvalid = 1'b1; w_res_tready = 1'b1;
        #1;
        for (int k = 0; k < 20 && !w_a_tready; k++) begin @(negedge clk); #1; end
        @(posedge clk);
        @(negedge clk);
        w_a_tvalid = 1'b0;
        lat = 1;
        #1;
        while (!w_res_tvalid && lat < 20) begin @(negedge clk); #1; lat++; end
        if (w_res_tvalid) begin res = w_res_tdata; flg = {w_ovf, w_unf, w_inv, w_inx}; end
        else begin res = 'x; flg = 'x; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n_res_tvalid !== 1'b0 || n_res_tdata !== 32'h0 || n_res_tuser !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h user=%h, need 0/0/0",
                     n_res_tvalid, n_res_tdata, n_res_tuser);
        end
        checks++;
        if ({n_ovf, n_unf, n_inv, n_inx} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b, need 0000", {n_ovf, n_unf, n_inv, n_inx});
        end
        checks++;
        if (n_a_tready !== 1'b0 || w_a_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready: got %b/%b, need 0/0", n_a_tready, w_a_tready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (n_a_tready !== 1'b1 || w_a_tready !== 1'b1 || w_res_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tready: got %b/%b (w valid %b), need 1/1 (0)",
                     n_a_tready, w_a_tready, w_res_tvalid);
        end
    endtask

    task automatic test_widen();
        logic [31:0] va [4];
        logic [63:0] vr [4];
        logic [3:0]  vf [4];
        logic [63:0] res;
        logic [3:0]  flg;
        va = '{32'h3F800000, 32'hC0490FDB, 32'h7F800001, 32'h00000001};
        vr = '{64'h3FF0000000000000, 64'hC00921FB60000000, 64'h7FF8000000000000, 64'h0};
        vf = '{4'b0000, 4'b0000, 4'b0010, 4'b0101};
        for (int i = 0; i < 4; i++) begin
            run_w(va[i], res, flg);
            checks++;
            if (res !== vr[i]) begin
                errors++;
                $display("FAIL widen[%0d] data: got %h need %h", i, res, vr[i]);
            end
            checks++;
            if (flg !== vf[i]) begin
                errors++;
                $display("FAIL widen[%0d] flags(ovf,unf,inv,inx): got %b need %b", i, flg, vf[i]);
            end
        end
    endtask

    // Shared table runner for the narrowing directed vectors of one feature
    task automatic test_table(input string name, input int n, input logic [63:0] va [8],
                              input logic [1:0] vm [8], input logic [31:0] vr [8],
                              input logic [3:0] vf [8]);
        logic [31:0] res;
        logic [3:0]  flg;
        logic [7:0]  usr;
        int          lat;
        for (int i = 0; i < n; i++) begin
            run_n(va[i], vm[i], 8'(i), res, flg, usr, lat);
            checks++;
            if (res !== vr[i]) begin
                errors++;
                $display("FAIL %s[%0d] data: got %h need %h", name, i, res, vr[i]);
            end
            checks++;
            if (flg !== vf[i]) begin
                errors++;
                $display("FAIL %s[%0d] flags(ovf,unf,inv,inx): got %b need %b", name, i, flg, vf[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [63:0] va [8]; logic [1:0] vm [8]; logic [31:0] vr [8]; logic [3:0] vf [8];
        va = '{64'h3FF0000010000000, 64'h3FF0000010000000, 64'h3FF0000010000000,
               64'hBFF0000010000000, 64'h3FFFFFFFFFFFFFFF, 64'h4000000000000000,
               64'h3FF0000030000000, 64'h3FF0000018000000};
        vm = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
        vr = '{32'h3F800000, 32'h3F800001, 32'h3F800000, 32'hBF800001, 32'h40000000,
               32'h40000000, 32'h3F800002, 32'h3F800000};
        vf = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
        test_table("round", 8, va, vm, vr, vf);
    endtask

    task automatic test_overflow();
        logic [63:0] va [8]; logic [1:0] vm [8]; logic [31:0] vr [8]; logic [3:0] vf [8];
        va = '{64'h47F0000000000000, 64'h47F0000000000000, 64'hC7F0000000000000,
               64'hC7F0000000000000, 64'h47F0000000000000, 64'h47EFFFFFF0000000,
               64'h47EFFFFFE0000000, 64'h47EFFFFFF0000000};
        vm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
        vr = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 32'h7F7FFFFF,
               32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFF};
        vf = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b0001};
        test_table("overflow", 8, va, vm, vr, vf);
    endtask

    task automatic test_underflow();
        logic [63:0] va [8]; logic [1:0] vm [8]; logic [31:0] vr [8]; logic [3:0] vf [8];
        va = '{64'h3690000000000000, 64'h0000000000000001, 64'h8000000000000001,
               64'h3810000000000000, 64'h3800000000000000, 64'hB800000000000000,
               64'h0, 64'h0};
        vm = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
        vr = '{32'h0, 32'h0, 32'h80000000, 32'h00800000, 32'h0, 32'h80000000, 32'h0, 32'h0};
        vf = '{4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 4'b0000};
        test_table("underflow", 6, va, vm, vr, vf);
    endtask

    task automatic test_specials();
        logic [63:0] va [8]; logic [1:0] vm [8]; logic [31:0] vr [8]; logic [3:0] vf [8];
        va = '{64'h7FF8000000000001, 64'h7FF0000000000001, 64'hFFF8000000000000,
               64'hFFF0000000000000, 64'h8000000000000000, 64'h0000000000000000,
               64'h0, 64'h0};
        vm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        vr = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
               32'h00000000, 32'h0, 32'h0};
        vf = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        test_table("special", 6, va, vm, vr, vf);
    endtask

    task automatic test_latency();
        logic [31:0] res; logic [3:0] flg; logic [7:0] usr; int lat;
        run_n(64'h3FF0000000000000, 2'd0, 8'hA5, res, flg, usr, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL latency: got %0d cycles need 3", lat);
        end
        checks++;
        if (usr !== 8'hA5) begin
            errors++;
            $display("FAIL latency_tuser: got %h need a5", usr);
        end
    endtask

    task automatic test_aclken();
        int k;
        @(negedge clk);
        aclken = 1'b0; n_res_tready = 1'b1;
        n_a_tdata = 64'h4000000000000000; n_mode = 2'd0; n_a_tuser = 8'h3C; n_a_tvalid = 1'b1;
        #1;
        checks++;
        if (n_a_tready !== 1'b0) begin
            errors++;
            $display("FAIL aclken_tready: got %b need 0", n_a_tready);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (n_res_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL aclken_hold: got valid %b need 0", n_res_tvalid);
        end
        aclken = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_a_tvalid = 1'b0;
        k = 0;
        #1;
        while (!n_res_tvalid && k < 20) begin @(negedge clk); #1; k++; end
        checks++;
        if (n_res_tvalid !== 1'b1 || n_res_tdata !== 32'h40000000 || n_res_tuser !== 8'h3C) begin
            errors++;
            $display("FAIL aclken_resume: got valid=%b data=%h user=%h need 1/40000000/3c",
                     n_res_tvalid, n_res_tdata, n_res_tuser);
        end
    endtask

    task automatic test_back_to_back();
        int          sent, recv, extra;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [7:0]  prev_user;
        sent = 0; recv = 0; prev_stall = 1'b0; prev_data = '0; prev_user = '0;
        for (int cyc = 0; cyc < 600 && recv < 16; cyc++) begin
            @(negedge clk);
            n_res_tready = ($urandom_range(0, 99) >= 40);
            n_a_tvalid   = (sent < 16) && ($urandom_range(0, 9) < 8);
            n_a_tdata    = 64'h3FF0000000000000 | (64'(sent) << 29);
            n_a_tuser    = 8'(sent);
            n_mode       = 2'd0;
            #1;
            if (prev_stall) begin
                checks++;
                if (n_res_tvalid !== 1'b1 || n_res_tdata !== prev_data || n_res_tuser !== prev_user) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%b data=%h user=%h need 1/%h/%h",
                             n_res_tvalid, n_res_tdata, n_res_tuser, prev_data, prev_user);
                end
            end
            if (n_a_tvalid && n_a_tready) sent++;
            if (n_res_tvalid && n_res_tready) begin
                checks++;
                if (n_res_tuser !== 8'(recv) || n_res_tdata !== (32'h3F800000 | 32'(recv))) begin
                    errors++;
                    $display("FAIL stream[%0d]: got data=%h user=%h need %h/%h", recv,
                             n_res_tdata, n_res_tuser, 32'h3F800000 | 32'(recv), 8'(recv));
                end
                recv++;
            end
            prev_stall = n_res_tvalid && !n_res_tready;
            prev_data  = n_res_tdata;
            prev_user  = n_res_tuser;
        end
        @(negedge clk);
        n_a_tvalid = 1'b0; n_res_tready = 1'b1;
        checks++;
        if (recv != 16) begin
            errors++;
            $display("FAIL stream_count: got %0d results need 16", recv);
        end
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (n_res_tvalid) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL stream_duplicate: got %0d extra results need 0", extra);
        end
    endtask

    task automatic test_reset_mid_stream();
        int stale;
        n_res_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_a_tvalid = 1'b1; n_a_tdata = 64'h4000000000000000; n_a_tuser = 8'(100 + i);
        end
        @(negedge clk);
        n_a_tvalid = 1'b0;
        #1;
        checks++;
        if (n_res_tvalid !== 1'b1 || n_res_tuser !== 8'd100) begin
            errors++;
            $display("FAIL midreset_fill: got valid=%b user=%0d need 1/100", n_res_tvalid, n_res_tuser);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (n_a_tready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_tready: got %b need 0", n_a_tready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (n_res_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid: got %b need 0", n_res_tvalid);
        end
        @(negedge clk);
        rst = 1'b0; n_res_tready = 1'b1;
        #1;
        checks++;
        if (n_a_tready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release: got tready %b need 1", n_a_tready);
        end
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (n_res_tvalid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midreset_stale: got %0d stale results need 0", stale);
        end
    endtask

    initial begin
        rst = 1'b1; aclken = 1'b1;
        w_a_tdata = '0; w_a_tuser = 1'b0; w_mode = 2'd0; w_a_tvalid = 1'b0; w_res_tready = 1'b1;
        n_a_tdata = '0; n_a_tuser = '0;   n_mode = 2'd0; n_a_tvalid = 1'b0; n_res_tready = 1'b1;
        test_reset();
        test_widen();
        test_latency();
        test_rounding();
        test_overflow();
        test_underflow();
        test_specials();
        test_aclken();
        test_back_to_back();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
